// File: rtl/vend_controller_if.sv
// Vending controller bus: handler/selection inputs and vend/refund outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; every request and pulse is a single-cycle event.
//
// Ports (master drives the requests, slave is the controller):
//   total_currency/currency_ready : running total from the currency handler
//   item_select/item_valid/cancel : selection and refund requests
//   credit/busy/dispense_*/change_*/insufficient/credit_overflow : controller status
interface vend_controller_if #(
   parameter int CURRENCY_WIDTH = 7
);
   logic [CURRENCY_WIDTH-1:0] total_currency;
   logic                      currency_ready;
   logic [1:0]                item_select;
   logic                      item_valid;
   logic                      cancel;
   logic [CURRENCY_WIDTH-1:0] credit;
   logic                      busy;
   logic                      dispense_valid;
   logic [1:0]                dispense_item;
   logic                      change_valid;
   logic [CURRENCY_WIDTH-1:0] change_value;
   logic                      insufficient;
   logic                      credit_overflow;

   modport master (
      output total_currency, currency_ready, item_select, item_valid, cancel,
      input  credit, busy, dispense_valid, dispense_item, change_valid,
             change_value, insufficient, credit_overflow
   );

   modport slave (
      input  total_currency, currency_ready, item_select, item_valid, cancel,
      output credit, busy, dispense_valid, dispense_item, change_valid,
             change_value, insufficient, credit_overflow
   );
endinterface

// File: rtl/vend_controller.sv
// Vending controller: turns the handler's running total into credit, vends from a fixed price table, pays change/refunds.
// Latency: item_valid in N -> dispense_valid in N+1 -> change_valid in N+2 (only when change is due).
// Backpressure: none; item_valid/cancel arriving while busy are dropped, never queued.
//
// Ports:
//   clk  : system clock
//   rstn : synchronous active-low reset
//   vif  : vend_controller_if slave (currency/selection inputs, credit/dispense/change/status outputs)
module vend_controller #(
   parameter int CURRENCY_WIDTH = 7,
   parameter int PRICE_0        = 25,
   parameter int PRICE_1        = 40,
   parameter int PRICE_2        = 50,
   parameter int PRICE_3        = 75
) (
   input logic               clk,
   input logic               rstn,
   vend_controller_if.slave  vif
);

   localparam int W = CURRENCY_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   state_t       state;
   logic [W-1:0] credit;
   logic [W-1:0] last_total;
   logic         credit_overflow;
   logic         dispense_valid;
   logic [1:0]   dispense_item;
   logic         change_valid;
   logic [W-1:0] change_value;
   logic         insufficient;

   logic [W-1:0] delta;
   logic [W-1:0] price_sel;
   logic         can_buy;
   logic         buy;
   logic [W-1:0] base;
   logic [W:0]   sum;
   logic         clip;
   logic [W-1:0] credit_nxt;

   function automatic logic [W-1:0] price_of(input logic [1:0] idx);
      case (idx)
         2'd0:    price_of = W'(PRICE_0);
         2'd1:    price_of = W'(PRICE_1);
         2'd2:    price_of = W'(PRICE_2);
         default: price_of = W'(PRICE_3);
      endcase
   endfunction

   // Credit datapath. The modular subtraction keeps the delta correct when
   // the upstream total wraps. Whatever the FSM does this cycle, the delta
   // is added on top of the base value and the result saturates.
   always_comb begin
      delta     = vif.currency_ready ? (vif.total_currency - last_total) : '0;
      price_sel = price_of(vif.item_select);
      can_buy   = (credit >= price_sel);
      buy       = (state == IDLE) && !vif.cancel && vif.item_valid && can_buy;
      base      = credit;
      if (buy) begin
         base = credit - price_sel;
      end else if (state == CHANGE) begin
         // Credit is paid out this cycle; only fresh money is kept.
         base = '0;
      end
      sum        = {1'b0, base} + {1'b0, delta};
      clip       = sum[W];
      credit_nxt = clip ? {W{1'b1}} : sum[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= IDLE;
         credit          <= '0;
         last_total      <= '0;
         credit_overflow <= 1'b0;
         dispense_valid  <= 1'b0;
         dispense_item   <= '0;
         change_valid    <= 1'b0;
         change_value    <= '0;
         insufficient    <= 1'b0;
      end else begin
         credit <= credit_nxt;
         if (clip) begin
            credit_overflow <= 1'b1;
         end
         if (vif.currency_ready) begin
            last_total <= vif.total_currency;
         end

         dispense_valid <= 1'b0;
         dispense_item  <= '0;
         change_valid   <= 1'b0;
         change_value   <= '0;
         insufficient   <= 1'b0;

         case (state)
            IDLE: begin
               // Cancel has priority; a selection in the same cycle is dropped
               // even when there is nothing to refund.
               if (vif.cancel) begin
                  if (credit != '0) begin
                     state        <= CHANGE;
                     change_valid <= 1'b1;
                     change_value <= credit_nxt;
                  end
               end else if (vif.item_valid) begin
                  if (can_buy) begin
                     state          <= VEND;
                     dispense_valid <= 1'b1;
                     dispense_item  <= vif.item_select;
                  end else begin
                     insufficient <= 1'b1;
                  end
               end
            end
            VEND: begin
               // The change pulse carries the credit register value that the
               // CHANGE cycle will hold, i.e. the remainder plus this delta.
               if (credit_nxt != '0) begin
                  state        <= CHANGE;
                  change_valid <= 1'b1;
                  change_value <= credit_nxt;
               end else begin
                  state <= IDLE;
               end
            end
            CHANGE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign vif.credit          = credit;
   assign vif.busy            = (state != IDLE);
   assign vif.dispense_valid  = dispense_valid;
   assign vif.dispense_item   = dispense_item;
   assign vif.change_valid    = change_valid;
   assign vif.change_value    = change_value;
   assign vif.insufficient    = insufficient;
   assign vif.credit_overflow = credit_overflow;

endmodule

// File: tb/tb_vend_controller.sv
// Testbench for vend_controller: directed vectors, a transaction-level model
// compared against the DUT every cycle, plus literal expectations.
module tb_vend_controller;

   localparam int W    = 7;
   localparam int MODV = 1 << W;
   localparam int MAXC = MODV - 1;

   logic clk;
   logic rstn;

   vend_controller_if #(.CURRENCY_WIDTH(W)) vif ();

   vend_controller #(
      .CURRENCY_WIDTH(W),
      .PRICE_0(25),
      .PRICE_1(40),
      .PRICE_2(50),
      .PRICE_3(75)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .vif  (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- behavioural model ----------------
   int prices[4] = '{25, 40, 50, 75};
   int m_credit  = 0;
   int m_last    = 0;
   int m_phase   = 0;   // 0: ready for requests, 1: dispensing, 2: paying out
   bit m_ovf     = 1'b0;
   bit e_dv      = 1'b0;
   int e_di      = 0;
   bit e_cv      = 1'b0;
   int e_cval    = 0;
   bit e_ins     = 1'b0;

   function automatic int sat(input int v);
      if (v > MAXC) begin
         m_ovf = 1'b1;
         return MAXC;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      int d;
      int old;
      if (!rstn) begin
         m_credit = 0; m_last = 0; m_phase = 0; m_ovf = 1'b0;
         e_dv = 1'b0; e_di = 0; e_cv = 1'b0; e_cval = 0; e_ins = 1'b0;
      end else begin
         d = 0;
         if (vif.currency_ready) begin
            d = ((int'(vif.total_currency) - m_last) % MODV + MODV) % MODV;
            m_last = int'(vif.total_currency);
         end
         e_dv = 1'b0; e_di = 0; e_cv = 1'b0; e_cval = 0; e_ins = 1'b0;
         old = m_credit;
         if (m_phase == 1) begin
            m_credit = sat(old + d);
            if (m_credit > 0) begin
               m_phase = 2; e_cv = 1'b1; e_cval = m_credit;
            end else begin
               m_phase = 0;
            end
         end else if (m_phase == 2) begin
            m_credit = d;
            m_phase  = 0;
         end else if (vif.cancel) begin
            m_credit = sat(old + d);
            if (old > 0) begin
               m_phase = 2; e_cv = 1'b1; e_cval = m_credit;
            end
         end else if (vif.item_valid) begin
            if (old >= prices[vif.item_select]) begin
               m_credit = sat(old - prices[vif.item_select] + d);
               m_phase  = 1; e_dv = 1'b1; e_di = int'(vif.item_select);
            end else begin
               m_credit = sat(old + d);
               e_ins    = 1'b1;
            end
         end else begin
            m_credit = sat(old + d);
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      checks++;
      if (vif.credit !== W'(m_credit) || vif.busy !== (m_phase != 0) ||
          vif.dispense_valid !== e_dv || vif.dispense_item !== 2'(e_di) ||
          vif.change_valid !== e_cv || vif.change_value !== W'(e_cval) ||
          vif.insufficient !== e_ins || vif.credit_overflow !== m_ovf) begin
         errors++;
         $display("FAIL model_cmp t=%0t got credit=%0d busy=%b dv=%b di=%0d cv=%b cval=%0d ins=%b ovf=%b, want credit=%0d busy=%b dv=%b di=%0d cv=%b cval=%0d ins=%b ovf=%b",
                  $time, vif.credit, vif.busy, vif.dispense_valid, vif.dispense_item,
                  vif.change_valid, vif.change_value, vif.insufficient, vif.credit_overflow,
                  m_credit, (m_phase != 0), e_dv, e_di, e_cv, e_cval, e_ins, m_ovf);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic lit(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic drive(input bit cr, input int tot, input bit iv, input int sel, input bit cn);
      vif.currency_ready = cr;
      if (cr) vif.total_currency = W'(tot);
      vif.item_valid  = iv;
      vif.item_select = 2'(sel);
      vif.cancel      = cn;
      @(negedge clk);
      vif.currency_ready = 1'b0;
      vif.item_valid     = 1'b0;
      vif.cancel         = 1'b0;
   endtask

   initial begin
      rstn               = 1'b0;
      vif.total_currency = '0;
      vif.currency_ready = 1'b0;
      vif.item_select    = '0;
      vif.item_valid     = 1'b0;
      vif.cancel         = 1'b0;
      tick(3);
      lit("reset_credit", int'(vif.credit), 0);
      lit("reset_busy", int'(vif.busy), 0);
      rstn = 1'b1;
      tick(10);
      lit("idle_credit", int'(vif.credit), 0);

      // 0 -> 20 -> 50, buy item 1 (40), expect change 10
      drive(1, 20, 0, 0, 0);
      drive(1, 50, 0, 0, 0);
      lit("credit_50", int'(vif.credit), 50);
      drive(0, 0, 1, 1, 0);
      lit("dispense_item1_valid", int'(vif.dispense_valid), 1);
      lit("dispense_item1_idx", int'(vif.dispense_item), 1);
      drive(0, 0, 1, 0, 1);              // requests while busy are ignored
      lit("change10_valid", int'(vif.change_valid), 1);
      lit("change10_value", int'(vif.change_value), 10);
      tick();
      lit("after_change_credit", int'(vif.credit), 0);
      lit("after_change_busy", int'(vif.busy), 0);

      // exact payment: 25 for item 0
      drive(1, 75, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      lit("exact_dispense", int'(vif.dispense_valid), 1);
      tick();
      lit("exact_no_change", int'(vif.change_valid), 0);
      lit("exact_credit", int'(vif.credit), 0);

      // credit 30, item 3 too expensive, then cancel
      drive(1, 105, 0, 0, 0);
      drive(0, 0, 1, 3, 0);
      lit("insufficient_pulse", int'(vif.insufficient), 1);
      lit("insufficient_no_disp", int'(vif.dispense_valid), 0);
      tick();
      lit("insufficient_credit", int'(vif.credit), 30);
      drive(0, 0, 0, 0, 1);
      lit("cancel30_value", int'(vif.change_value), 30);
      tick();

      // upstream wrap: 120 -> 10 is a delta of 18
      drive(1, 120, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      tick();
      drive(1, 10, 0, 0, 0);
      lit("wrap_credit", int'(vif.credit), 18);
      drive(0, 0, 0, 0, 1);
      tick();

      // money arriving in the payout cycle is kept
      drive(1, 60, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      tick();
      lit("payout_change_value", int'(vif.change_value), 10);
      drive(1, 65, 0, 0, 0);
      lit("payout_kept_credit", int'(vif.credit), 5);
      drive(0, 0, 0, 0, 1);
      tick();

      // cancel beats a simultaneous selection
      drive(1, 125, 0, 0, 0);
      drive(0, 0, 1, 0, 1);
      lit("cancel_wins_value", int'(vif.change_value), 60);
      lit("cancel_wins_no_disp", int'(vif.dispense_valid), 0);
      tick();

      // saturation and sticky overflow
      lit("ovf_clear", int'(vif.credit_overflow), 0);
      drive(1, 97, 0, 0, 0);
      drive(1, 69, 0, 0, 0);
      lit("sat_credit", int'(vif.credit), 127);
      lit("ovf_set", int'(vif.credit_overflow), 1);
      drive(0, 0, 0, 0, 1);
      lit("sat_refund", int'(vif.change_value), 127);
      tick();
      lit("ovf_sticky", int'(vif.credit_overflow), 1);

      // reset in the middle of a vend aborts it
      drive(1, 119, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      rstn = 1'b0;
      tick();
      lit("midreset_credit", int'(vif.credit), 0);
      lit("midreset_busy", int'(vif.busy), 0);
      rstn = 1'b1;
      tick();
      lit("midreset_no_change", int'(vif.change_valid), 0);
      lit("midreset_ovf", int'(vif.credit_overflow), 0);
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
